// File: rtl/avl_uart_slave_if.sv
// Avalon-MM register-window bus between the core's data master and the UART slave.
interface avl_uart_slave_if;
  logic [1:0]  address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport slave  (input  address, byteenable, read, write, writedata,
                  output readdata, waitrequest);
  modport master (output address, byteenable, read, write, writedata,
                  input  readdata, waitrequest);
endinterface

// File: rtl/avl_uart_slave.sv
// Avalon-MM 8N1 UART: TX FIFO, single-byte RX holding register, programmable divisor, level IRQ.
module avl_uart_slave #(
  parameter int unsigned DIV_RESET  = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  avl_uart_slave_if.slave avl,
  input  logic            uart_rx,
  output logic            uart_tx,
  output logic            irq
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DIV_W = 16;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_BAUD = 2'd2, A_CTRL = 2'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic [DIV_W-1:0] div;
  logic             rx_ie, tx_ie, rd_phase;
  logic             rx_valid, overrun, frame_err;
  logic [7:0]       rx_byte;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             tx_full, tx_empty, push, fifo_pop;

  tx_state_t        tx_state, tx_state_n;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic             tx_line_n;
  logic [7:0]       tx_data;

  rx_state_t        rx_state, rx_state_n;
  logic [DIV_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_load, ferr_set;
  logic [1:0]       rx_sync;
  logic             rx_s, rx_prev;

  logic             rd_first, rd_done, wr_acc, wr_data, rx_pop;
  logic [31:0]      status, rd_mux;
  logic             unused;

  assign unused = ^{avl.byteenable, avl.writedata[31:16]};

  // Bus decode: reads always take one wait state; DATA writes stall only on a full FIFO with no pop.
  assign rd_first        = avl.read && !rd_phase;
  assign rd_done         = avl.read && rd_phase;
  assign wr_acc          = avl.write && !avl.read;
  assign wr_data         = wr_acc && (avl.address == A_DATA);
  assign tx_full         = (count == CNT_W'(FIFO_DEPTH));
  assign tx_empty        = (count == '0) && (tx_state == TX_IDLE);
  assign push            = wr_data && !(tx_full && !fifo_pop);
  assign avl.waitrequest = rd_first || (wr_data && tx_full && !fifo_pop);
  assign rx_pop          = rd_done && (avl.address == A_DATA) && rx_valid;
  assign rx_s            = rx_sync[1];

  assign status = {19'b0, 4'(count), 4'b0, frame_err, overrun, rx_valid, tx_empty, tx_full};

  always_comb begin
    rd_mux = '0;
    case (avl.address)
      A_DATA:   rd_mux = rx_valid ? {24'b0, rx_byte} : '0;
      A_STATUS: rd_mux = status;
      A_BAUD:   rd_mux = {16'b0, div};
      default:  rd_mux = {30'b0, tx_ie, rx_ie};
    endcase
  end

  // Register file, RX holding register and IRQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avl.readdata <= '0;
      rd_phase     <= 1'b0;
      div          <= DIV_W'(DIV_RESET);
      rx_ie        <= 1'b0;
      tx_ie        <= 1'b0;
      rx_valid     <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
      rx_byte      <= '0;
      irq          <= 1'b0;
    end else begin
      rd_phase <= rd_first;
      if (rd_first) avl.readdata <= rd_mux;
      if (wr_acc && avl.address == A_BAUD)
        div <= (avl.writedata[15:0] < 16'd2) ? DIV_W'(2) : avl.writedata[15:0];
      if (wr_acc && avl.address == A_CTRL) begin
        rx_ie <= avl.writedata[0];
        tx_ie <= avl.writedata[1];
      end
      // Set beats W1C; a load beats a same-cycle pop and does not count as overrun.
      if (rx_load) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
      if (rx_load && rx_valid && !rx_pop) overrun <= 1'b1;
      else if (wr_acc && avl.address == A_STATUS && avl.writedata[3]) overrun <= 1'b0;
      if (ferr_set) frame_err <= 1'b1;
      else if (wr_acc && avl.address == A_STATUS && avl.writedata[4]) frame_err <= 1'b0;
      irq <= (rx_valid && rx_ie) || (tx_empty && tx_ie);
    end
  end

  // TX FIFO storage carries no reset; pointers and count do.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avl.writedata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tx_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        tx_data <= mem[rd_ptr];
      end
      count <= count + CNT_W'(push) - CNT_W'(fifo_pop);
    end
  end

  // TX FSM state register; uart_tx is registered from the next-state logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      uart_tx  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_line_n  = uart_tx;
    fifo_pop   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (count != '0) begin
          fifo_pop   = 1'b1;
          tx_state_n = TX_START;
          tx_cnt_n   = div - DIV_W'(1);
          tx_line_n  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = div - DIV_W'(1);
          tx_bit_n   = '0;
          tx_line_n  = tx_data[0];
        end else tx_cnt_n = tx_cnt - DIV_W'(1);
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_n = div - DIV_W'(1);
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_bit_n  = tx_bit + 3'd1;
            tx_line_n = tx_data[tx_bit_n];
          end
        end else tx_cnt_n = tx_cnt - DIV_W'(1);
      end
      default: begin
        if (tx_cnt == '0) begin
          if (count != '0) begin
            fifo_pop   = 1'b1;
            tx_state_n = TX_START;
            tx_cnt_n   = div - DIV_W'(1);
            tx_line_n  = 1'b0;
          end else begin
            tx_state_n = TX_IDLE;
            tx_line_n  = 1'b1;
          end
        end else tx_cnt_n = tx_cnt - DIV_W'(1);
      end
    endcase
  end

  // RX synchronizer and FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rx};
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_load    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_n = RX_START;
          rx_cnt_n   = (div >> 1) - DIV_W'(1);
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rx_s) rx_state_n = RX_IDLE;
          else begin
            rx_state_n = RX_DATA;
            rx_cnt_n   = div - DIV_W'(1);
            rx_bit_n   = '0;
          end
        end else rx_cnt_n = rx_cnt - DIV_W'(1);
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_cnt_n   = div - DIV_W'(1);
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else rx_bit_n = rx_bit + 3'd1;
        end else rx_cnt_n = rx_cnt - DIV_W'(1);
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          if (rx_s) begin
            rx_load    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            ferr_set   = 1'b1;
            rx_state_n = RX_WAIT;
          end
        end else rx_cnt_n = rx_cnt - DIV_W'(1);
      end
      default: begin
        if (rx_s) rx_state_n = RX_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_avl_uart_slave.sv
// Directed/random bench for avl_uart_slave: serial decoder on uart_tx, serial driver on uart_rx, flag model.
module tb_avl_uart_slave;
  logic clk, reset, uart_rx, uart_tx, irq;
  avl_uart_slave_if bus();

  avl_uart_slave #(.DIV_RESET(434), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .avl(bus), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model of the RX flags and holding register.
  logic       m_valid, m_ovr, m_ferr;
  logic [7:0] m_byte;

  // Serial frames decoded from uart_tx.
  logic [7:0] got_b[$];
  logic       got_stop[$];
  int         got_s[$];
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         tx_div = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic ferr, input logic ovr, input logic rxv);
    return {27'b0, ferr, ovr, rxv, 1'b1, 1'b0}; // TX idle and empty
  endfunction

  task automatic avl_write(input logic [1:0] a, input logic [31:0] d, output int waits);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.write = 1'b1; waits = 0;
    #1;
    while (bus.waitrequest === 1'b1 && waits < 5000) begin @(negedge clk); #1; waits++; end
    if (waits >= 5000) chk("write_timeout", 32'(bus.waitrequest), 32'd0);
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int w;
    avl_write(a, d, w);
  endtask

  task automatic avl_read(input logic [1:0] a, output logic [31:0] data, output int waits);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1; waits = 0;
    #1;
    while (bus.waitrequest === 1'b1 && waits < 100) begin @(negedge clk); #1; waits++; end
    if (waits >= 100) chk("read_timeout", 32'(bus.waitrequest), 32'd0);
    data = bus.readdata;
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    avl_read(a, d, w);
    chk(tag, d, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int div);
    uart_rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (div) @(negedge clk); end
    uart_rx = stop_bit;
    repeat (div) @(negedge clk);
    uart_rx = 1'b1;
    repeat (div) @(negedge clk);
    if (stop_bit) begin
      if (m_valid) m_ovr = 1'b1;
      m_byte = b; m_valid = 1'b1;
    end else m_ferr = 1'b1;
  endtask

  task automatic read_data_model(input string tag);
    logic [31:0] d;
    int w;
    avl_read(2'd0, d, w);
    chk(tag, d, m_valid ? {24'b0, m_byte} : 32'd0);
    m_valid = 1'b0;
  endtask

  // Decodes uart_tx frames by sampling mid-bit.
  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (mon_en && uart_tx === 1'b0) begin : frame
        int s;
        logic [7:0] b;
        s = cyc;
        repeat (tx_div / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin repeat (tx_div) @(negedge clk); b[i] = uart_tx; end
        repeat (tx_div) @(negedge clk);
        got_b.push_back(b); got_stop.push_back(uart_tx); got_s.push_back(s);
      end
    end
  end

  initial begin : main
    logic [31:0] d;
    int w, t;
    int waits[10];
    logic [7:0] b1, b2;
    reset = 1'b1; uart_rx = 1'b1;
    bus.address = '0; bus.byteenable = 4'hF; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = '0;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_waitreq", 32'(bus.waitrequest), 32'd0);
    reset = 1'b0;

    avl_read(2'd1, d, w);
    chk("rst_status", d, st(0, 0, 0));
    chk("read_wait_states", 32'(w), 32'd1);
    rd_chk("rst_baud", 2'd2, 32'd434);
    rd_chk("rst_ctrl", 2'd3, 32'd0);
    wr(2'd2, 32'd1);
    rd_chk("baud_min_clamp", 2'd2, 32'd2);
    wr(2'd2, 32'h0001_0004);
    rd_chk("baud_16bit", 2'd2, 32'd4);

    // Single frame 0x55 at 4 clk/bit.
    mon_en = 1'b1;
    avl_write(2'd0, 32'h55, w);
    exp_q.push_back(8'h55);
    chk("tx1_write_wait", 32'(w), 32'd0);
    avl_read(2'd1, d, w);
    chk("tx1_busy_empty", d & 32'h3, 32'd0);
    t = 0;
    while (got_b.size() < 1 && t < 500) begin @(negedge clk); t++; end
    chk("tx1_frames", 32'(got_b.size()), 32'd1);
    repeat (4) @(negedge clk);
    rd_chk("tx1_idle_status", 2'd1, st(0, 0, 0));

    // Ten random bytes: nine fit (the first is popped at once), the tenth stalls.
    for (int i = 0; i < 10; i++) begin
      b1 = 8'($urandom);
      exp_q.push_back(b1);
      avl_write(2'd0, {24'b0, b1}, waits[i]);
    end
    for (int i = 0; i < 9; i++) chk($sformatf("tx2_nowait_%0d", i), 32'(waits[i]), 32'd0);
    chk("tx2_full_stall", 32'(waits[9] > 0), 32'd1);
    t = 0;
    while (got_b.size() < 11 && t < 1000) begin @(negedge clk); t++; end
    chk("tx2_frames", 32'(got_b.size()), 32'd11);
    for (int i = 0; i < 11 && i < got_b.size(); i++) begin
      chk($sformatf("tx_byte_%0d", i), 32'(got_b[i]), 32'(exp_q[i]));
      chk($sformatf("tx_stop_%0d", i), 32'(got_stop[i]), 32'd1);
      if (i >= 2) chk($sformatf("tx_gap_%0d", i), 32'(got_s[i] - got_s[i-1]), 32'd40);
    end
    repeat (4) @(negedge clk);
    rd_chk("tx2_idle_status", 2'd1, st(0, 0, 0));
    mon_en = 1'b0;

    // RX at divisor 8.
    wr(2'd2, 32'd8);
    send_byte(8'hA3, 1'b1, 8);
    rd_chk("rx_valid_status", 2'd1, st(m_ferr, m_ovr, m_valid));
    avl_read(2'd0, d, w);
    chk("rx_data_a3", d, 32'h0000_00A3);
    chk("rx_data_wait", 32'(w), 32'd1);
    m_valid = 1'b0;
    rd_chk("rx_popped_status", 2'd1, st(m_ferr, m_ovr, m_valid));
    read_data_model("rx_empty_data");
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom), 1'b1, 8);
      read_data_model($sformatf("rx_rand_%0d", i));
    end

    // Overrun and W1C.
    b1 = 8'($urandom); b2 = 8'($urandom);
    send_byte(b1, 1'b1, 8);
    send_byte(b2, 1'b1, 8);
    rd_chk("ovr_status", 2'd1, st(m_ferr, m_ovr, m_valid));
    wr(2'd1, 32'h08);
    m_ovr = 1'b0;
    rd_chk("ovr_w1c_status", 2'd1, st(m_ferr, m_ovr, m_valid));
    read_data_model("ovr_data");

    // Framing error keeps the held byte; glitch is rejected.
    send_byte(8'h3C, 1'b1, 8);
    send_byte(8'hF0, 1'b0, 8);
    rd_chk("ferr_status", 2'd1, st(m_ferr, m_ovr, m_valid));
    read_data_model("ferr_data");
    wr(2'd1, 32'h10);
    m_ferr = 1'b0;
    rd_chk("ferr_w1c_status", 2'd1, st(m_ferr, m_ovr, m_valid));
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    rd_chk("glitch_status", 2'd1, st(m_ferr, m_ovr, m_valid));
    send_byte(8'h81, 1'b1, 8);
    read_data_model("post_glitch_data");

    // IRQ behaviour.
    wr(2'd3, 32'd1);
    repeat (2) @(negedge clk);
    chk("irq_rx_idle", 32'(irq), 32'd0);
    send_byte(8'h5A, 1'b1, 8);
    chk("irq_rx_set", 32'(irq), 32'd1);
    read_data_model("irq_data");
    @(negedge clk);
    chk("irq_hold_cycle", 32'(irq), 32'd1);
    @(negedge clk);
    chk("irq_rx_clear", 32'(irq), 32'd0);
    wr(2'd3, 32'd2);
    repeat (2) @(negedge clk);
    chk("irq_tx_empty", 32'(irq), 32'd1);
    wr(2'd3, 32'd0);
    repeat (2) @(negedge clk);
    chk("irq_off", 32'(irq), 32'd0);

    // Reset in the middle of a frame.
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h00);
    wr(2'd0, 32'h77);
    t = 0;
    while (uart_tx !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    chk("midtx_started", 32'(uart_tx), 32'd0);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("midtx_reset_tx", 32'(uart_tx), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("midtx_status", 2'd1, st(0, 0, 0));
    rd_chk("midtx_baud", 2'd2, 32'd434);
    repeat (20) @(negedge clk);
    chk("midtx_line_idle", 32'(uart_tx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
